mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single unified instruction/data memory between the multicycle CPU and a debug/loader port.
- Sits between the CPU memory interface (the IorD-selected address path) and the memory macro.
- Sequences each access through a fixed-latency memory and returns data with a one-cycle Ready pulse.
- Gives the CPU a stall point, and gives the loader a way to halt the CPU and access memory.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_rr2.sv | 24 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding (also the Stat readout encoding) and requester identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Requester identifiers, also the encoding of the LastGnt register.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Stat readout values, identical to the state encoding.
  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b01;
  localparam logic [1:0] STAT_RESP = 2'b10;

  function automatic logic [1:0] stat_of(state_e s);
    return s;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Stateless two-way round-robin pick. On a tie the requester that did not
// win last time is chosen; the history register lives in the caller.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_c_i,
  input  logic req_d_i,
  input  logic last_gnt_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  // Pick a winner from the effective requests and the last owner.
  always_comb begin
    gnt_vld_o = req_c_i | req_d_i;
    gnt_id_o  = REQ_CPU;
    if (req_c_i && req_d_i) begin
      gnt_id_o = (last_gnt_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req_d_i) begin
      gnt_id_o = REQ_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between the CPU and the
// debug/loader port. Each access is IDLE -> BUSY (LAT cycles) -> RESP, with
// a one-cycle Ready pulse to the owner in RESP. DbgHalt masks the CPU at
// arbitration time only; transactions in flight always complete.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic [DW-1:0] CpuRData,
  output logic          CpuReady,
  input  logic          DbgReq,
  input  logic          DbgWe,
  input  logic [AW-1:0] DbgAddr,
  input  logic [DW-1:0] DbgWData,
  output logic [DW-1:0] DbgRData,
  output logic          DbgReady,
  input  logic          DbgHalt,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemWe,
  output logic          MemEn,
  input  logic [DW-1:0] MemRData,
  output logic          CpuGnt,
  output logic          DbgGnt,
  output logic [1:0]    Stat
);

  // Counter only has to reach LAT-1, so it never wraps inside a transaction.
  localparam int            CW       = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          last_gnt_q;
  logic          is_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic          mem_en_q;
  logic          cpu_gnt_q;
  logic          dbg_gnt_q;
  logic          cpu_rdy_q;
  logic          dbg_rdy_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  logic          req_c;
  logic          req_d;
  logic          pick_vld;
  logic          pick_id;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          we_d;

  assign req_c = CpuReq & ~DbgHalt;
  assign req_d = DbgReq;

  arb_rr2 u_pick (
    .req_c_i    (req_c),
    .req_d_i    (req_d),
    .last_gnt_i (last_gnt_q),
    .gnt_vld_o  (pick_vld),
    .gnt_id_o   (pick_id)
  );

  // Route the winning requester's command toward the memory registers.
  always_comb begin
    addr_d  = CpuAddr;
    wdata_d = CpuWData;
    we_d    = CpuWe;
    if (pick_id == REQ_DBG) begin
      addr_d  = DbgAddr;
      wdata_d = DbgWData;
      we_d    = DbgWe;
    end
  end

  // Transaction sequencer with registered memory, grant and ready outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= REQ_CPU;
      is_wr_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      cpu_rdy_q   <= 1'b0;
      dbg_rdy_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            last_gnt_q  <= pick_id;
            is_wr_q     <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_we_q    <= we_d;
            mem_en_q    <= 1'b1;
            cpu_gnt_q   <= (pick_id == REQ_CPU);
            dbg_gnt_q   <= (pick_id == REQ_DBG);
          end
        end
        BUSY: begin
          // The write strobe lasts only for the first BUSY cycle.
          mem_we_q <= 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_q   <= RESP;
            mem_en_q  <= 1'b0;
            cpu_rdy_q <= cpu_gnt_q;
            dbg_rdy_q <= dbg_gnt_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (!is_wr_q) begin
            if (cpu_gnt_q) cpu_rdata_q <= MemRData;
            if (dbg_gnt_q) dbg_rdata_q <= MemRData;
          end
          cpu_rdy_q <= 1'b0;
          dbg_rdy_q <= 1'b0;
          cpu_gnt_q <= 1'b0;
          dbg_gnt_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          // Unused encoding: drop everything and resume arbitration.
          state_q   <= IDLE;
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          cpu_gnt_q <= 1'b0;
          dbg_gnt_q <= 1'b0;
          cpu_rdy_q <= 1'b0;
          dbg_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemWe    = mem_we_q;
  assign MemEn    = mem_en_q;
  assign CpuGnt   = cpu_gnt_q;
  assign DbgGnt   = dbg_gnt_q;
  assign CpuReady = cpu_rdy_q;
  assign DbgReady = dbg_rdy_q;
  assign CpuRData = cpu_rdata_q;
  assign DbgRData = dbg_rdata_q;
  assign Stat     = stat_of(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a LAT=2 instance with a behavioural
// memory and a LAT=1 instance with a constant read-data source.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  // LAT=2 instance signals
  logic          CpuReq, CpuWe, DbgReq, DbgWe, DbgHalt;
  logic [AW-1:0] CpuAddr, DbgAddr, MemAddr;
  logic [DW-1:0] CpuWData, DbgWData, CpuRData, DbgRData, MemWData, MemRData;
  logic          CpuReady, DbgReady, MemWe, MemEn, CpuGnt, DbgGnt;
  logic [1:0]    Stat;

  // LAT=1 instance signals
  logic          CpuReq1, CpuWe1, DbgReq1, DbgWe1, DbgHalt1;
  logic [AW-1:0] CpuAddr1, DbgAddr1, MemAddr1;
  logic [DW-1:0] CpuWData1, DbgWData1, CpuRData1, DbgRData1, MemWData1, MemRData1;
  logic          CpuReady1, DbgReady1, MemWe1, MemEn1, CpuGnt1, DbgGnt1;
  logic [1:0]    Stat1;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(2)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuRData(CpuRData), .CpuReady(CpuReady),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgRData(DbgRData), .DbgReady(DbgReady), .DbgHalt(DbgHalt),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWe(MemWe), .MemEn(MemEn),
    .MemRData(MemRData), .CpuGnt(CpuGnt), .DbgGnt(DbgGnt), .Stat(Stat)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (
    .CLK(CLK), .Reset(Reset),
    .CpuReq(CpuReq1), .CpuWe(CpuWe1), .CpuAddr(CpuAddr1), .CpuWData(CpuWData1),
    .CpuRData(CpuRData1), .CpuReady(CpuReady1),
    .DbgReq(DbgReq1), .DbgWe(DbgWe1), .DbgAddr(DbgAddr1), .DbgWData(DbgWData1),
    .DbgRData(DbgRData1), .DbgReady(DbgReady1), .DbgHalt(DbgHalt1),
    .MemAddr(MemAddr1), .MemWData(MemWData1), .MemWe(MemWe1), .MemEn(MemEn1),
    .MemRData(MemRData1), .CpuGnt(CpuGnt1), .DbgGnt(DbgGnt1), .Stat(Stat1)
  );

  // Behavioural memory: unwritten words return a fixed address pattern.
  logic [DW-1:0] mem [256];
  bit            written [256];

  function automatic logic [DW-1:0] pattern(int idx);
    if (idx == 4) return 32'hDEADBEEF;
    return 32'h5A00_0000 | (idx * 32'h0001_0101);
  endfunction

  assign MemRData = written[MemAddr[9:2]] ? mem[MemAddr[9:2]] : pattern(int'(MemAddr[9:2]));

  always @(posedge CLK) begin
    if (MemEn && MemWe) begin
      mem[MemAddr[9:2]]     <= MemWData;
      written[MemAddr[9:2]] <= 1'b1;
    end
  end

  // Reference contents used to form expectations at issue time.
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr  [256];

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  exp_t ce, de;
  logic [DW-1:0] cpu_rd_exp, dbg_rd_exp;
  bit   cpu_chk, dbg_chk;
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t expect_for(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t e;
    int   idx = int'(a[9:2]);
    e.we = we;
    if (we) begin
      ref_mem[idx] = d;
      ref_wr[idx]  = 1'b1;
      e.data = d;
    end else begin
      e.data = ref_wr[idx] ? ref_mem[idx] : pattern(idx);
    end
    return e;
  endfunction

  task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CpuReq = 1'b1; CpuWe = we; CpuAddr = a; CpuWData = d;
    cpu_q.push_back(expect_for(we, a, d));
  endtask

  task automatic dbg_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    DbgReq = 1'b1; DbgWe = we; DbgAddr = a; DbgWData = d;
    dbg_q.push_back(expect_for(we, a, d));
  endtask

  task automatic idle_inputs();
    CpuReq = 0; CpuWe = 0; CpuAddr = '0; CpuWData = '0;
    DbgReq = 0; DbgWe = 0; DbgAddr = '0; DbgWData = '0; DbgHalt = 0;
    CpuReq1 = 0; CpuWe1 = 0; CpuAddr1 = '0; CpuWData1 = '0;
    DbgReq1 = 0; DbgWe1 = 0; DbgAddr1 = '0; DbgWData1 = '0; DbgHalt1 = 0;
    MemRData1 = 32'h0BAD_F00D;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    cpu_q.delete(); dbg_q.delete();
    cpu_rd_exp = '0; dbg_rd_exp = '0;
    cpu_chk = 0; dbg_chk = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (Stat !== 2'b00) begin failures++; $display("FAIL reset_stat: got %b want 00", Stat); end
    checks++;
    if ({MemEn, MemWe, CpuReady, DbgReady, CpuGnt, DbgGnt} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000000", {MemEn, MemWe, CpuReady, DbgReady, CpuGnt, DbgGnt});
    end
    checks++;
    if ({MemAddr, MemWData, CpuRData, DbgRData} !== '0) begin
      failures++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h want all 0", MemAddr, MemWData, CpuRData, DbgRData);
    end
    checks++;
    if ({Stat1, MemEn1, CpuReady1} !== 4'b0) begin failures++; $display("FAIL reset_lat1: got %b want 0000", {Stat1, MemEn1, CpuReady1}); end
    Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (Stat !== 2'b00 || MemEn !== 1'b0) begin failures++; $display("FAIL idle_hold c=%0d: Stat=%b MemEn=%b want 00/0", c, Stat, MemEn); end
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    cpu_issue(1'b0, 32'h10, '0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      if (cpu_chk) begin
        checks++;
        if (CpuRData !== cpu_rd_exp) begin failures++; $display("FAIL single_rdata: got %h want %h", CpuRData, cpu_rd_exp); end
        cpu_chk = 0;
      end
      checks++;
      if (CpuReady !== (c == 3)) begin failures++; $display("FAIL single_ready c=%0d: got %b want %b", c, CpuReady, (c == 3)); end
      checks++;
      if (DbgReady !== 1'b0) begin failures++; $display("FAIL single_dbgready c=%0d: got %b want 0", c, DbgReady); end
      if (CpuReady) begin
        ce = cpu_q.pop_front();
        if (!ce.we) cpu_rd_exp = ce.data;
        cpu_chk = 1; CpuReq = 0;
      end
    end
    checks++;
    if (cpu_q.size() != 0) begin failures++; $display("FAIL single_sb: %0d left want 0", cpu_q.size()); end
  endtask

  task automatic test_alternation();
    apply_reset();
    cpu_issue(1'b0, 32'h30, '0);
    dbg_issue(1'b0, 32'h20, '0);
    dbg_q.push_back(dbg_q[0]);
    for (int c = 1; c <= 13; c++) begin
      @(posedge CLK); #1;
      if (cpu_chk) begin
        checks++;
        if (CpuRData !== cpu_rd_exp) begin failures++; $display("FAIL alt_cpu_rdata: got %h want %h", CpuRData, cpu_rd_exp); end
        cpu_chk = 0;
      end
      if (dbg_chk) begin
        checks++;
        if (DbgRData !== dbg_rd_exp) begin failures++; $display("FAIL alt_dbg_rdata: got %h want %h", DbgRData, dbg_rd_exp); end
        dbg_chk = 0;
      end
      checks++;
      if (CpuReady !== (c == 7) || DbgReady !== (c == 3 || c == 11)) begin
        failures++; $display("FAIL alt_ready c=%0d: cpu=%b dbg=%b want %b %b", c, CpuReady, DbgReady, (c == 7), (c == 3 || c == 11));
      end
      checks++;
      if (CpuGnt && DbgGnt) begin failures++; $display("FAIL alt_onehot c=%0d: both grants high", c); end
      if (CpuReady) begin ce = cpu_q.pop_front(); cpu_rd_exp = ce.data; cpu_chk = 1; end
      if (DbgReady) begin de = dbg_q.pop_front(); dbg_rd_exp = de.data; dbg_chk = 1; end
      if (c == 11) begin CpuReq = 0; DbgReq = 0; end
    end
    checks++;
    if (cpu_q.size() != 0 || dbg_q.size() != 0) begin failures++; $display("FAIL alt_sb: cpu=%0d dbg=%0d left want 0 0", cpu_q.size(), dbg_q.size()); end
  endtask

  task automatic test_dbg_write_halt();
    apply_reset();
    DbgHalt = 1'b1;
    cpu_issue(1'b0, 32'h50, '0);
    dbg_issue(1'b1, 32'h40, 32'h1234_5678);
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      if (cpu_chk) begin
        checks++;
        if (CpuRData !== cpu_rd_exp) begin failures++; $display("FAIL halt_cpu_rdata: got %h want %h", CpuRData, cpu_rd_exp); end
        cpu_chk = 0;
      end
      if (dbg_chk) begin
        checks++;
        if (DbgRData !== dbg_rd_exp) begin failures++; $display("FAIL halt_dbg_rdata: got %h want %h", DbgRData, dbg_rd_exp); end
        dbg_chk = 0;
      end
      checks++;
      if (CpuGnt !== (c >= 8 && c <= 10) || DbgGnt !== ((c >= 1 && c <= 3) || (c >= 12 && c <= 14))) begin
        failures++; $display("FAIL halt_gnt c=%0d: cpu=%b dbg=%b", c, CpuGnt, DbgGnt);
      end
      checks++;
      if (MemWe !== (c == 1)) begin failures++; $display("FAIL halt_we c=%0d: got %b want %b", c, MemWe, (c == 1)); end
      if (c == 1) begin
        checks++;
        if (MemAddr !== 32'h40 || MemWData !== 32'h1234_5678) begin
          failures++; $display("FAIL halt_wcmd: addr=%h data=%h want 00000040 12345678", MemAddr, MemWData);
        end
      end
      checks++;
      if (CpuReady !== (c == 10) || DbgReady !== (c == 3 || c == 14)) begin
        failures++; $display("FAIL halt_ready c=%0d: cpu=%b dbg=%b", c, CpuReady, DbgReady);
      end
      if (CpuReady) begin
        ce = cpu_q.pop_front(); cpu_rd_exp = ce.data; cpu_chk = 1; CpuReq = 0;
      end
      if (DbgReady) begin
        de = dbg_q.pop_front();
        if (!de.we) dbg_rd_exp = de.data;
        dbg_chk = 1; DbgReq = 0;
      end
      if (c == 7) DbgHalt = 1'b0;
      if (c == 8) begin
        checks++;
        if (Stat !== 2'b01) begin failures++; $display("FAIL halt_cpu_busy: Stat=%b want 01", Stat); end
      end
      if (c == 11) dbg_issue(1'b0, 32'h40, '0);
    end
    checks++;
    if (cpu_q.size() != 0 || dbg_q.size() != 0) begin failures++; $display("FAIL halt_sb: cpu=%0d dbg=%0d left want 0 0", cpu_q.size(), dbg_q.size()); end
  endtask

  task automatic test_drop_mid();
    apply_reset();
    cpu_issue(1'b1, 32'h60, 32'hCAFE_F00D);
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (cpu_chk) begin
        checks++;
        if (CpuRData !== cpu_rd_exp) begin failures++; $display("FAIL drop_rdata c=%0d: got %h want %h", c, CpuRData, cpu_rd_exp); end
        cpu_chk = 0;
      end
      checks++;
      if (MemWe !== (c == 1)) begin failures++; $display("FAIL drop_we c=%0d: got %b want %b", c, MemWe, (c == 1)); end
      checks++;
      if (CpuReady !== (c == 3 || c == 7) || DbgReady !== 1'b0) begin
        failures++; $display("FAIL drop_ready c=%0d: cpu=%b dbg=%b", c, CpuReady, DbgReady);
      end
      if (c == 1) CpuReq = 0;
      if (CpuReady) begin
        ce = cpu_q.pop_front();
        if (!ce.we) cpu_rd_exp = ce.data;
        cpu_chk = 1; CpuReq = 0;
      end
      if (c == 4) cpu_issue(1'b0, 32'h60, '0);
    end
    checks++;
    if (cpu_q.size() != 0) begin failures++; $display("FAIL drop_sb: %0d left want 0", cpu_q.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cpu_issue(1'b0, 32'h70, '0);
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (Stat !== 2'b01) begin failures++; $display("FAIL rmid_busy: Stat=%b want 01", Stat); end
    Reset = 1'b1;
    #1;
    checks++;
    if (Stat !== 2'b00 || MemEn !== 1'b0 || CpuGnt !== 1'b0) begin
      failures++; $display("FAIL rmid_async: Stat=%b MemEn=%b CpuGnt=%b want 00 0 0", Stat, MemEn, CpuGnt);
    end
    cpu_q.delete(); CpuReq = 0;
    @(posedge CLK); #1 Reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (CpuReady !== 1'b0 || DbgReady !== 1'b0) begin failures++; $display("FAIL rmid_noready c=%0d: cpu=%b dbg=%b", c, CpuReady, DbgReady); end
    end
    cpu_issue(1'b0, 32'h30, '0);
    dbg_issue(1'b0, 32'h20, '0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (cpu_chk) begin
        checks++;
        if (CpuRData !== cpu_rd_exp) begin failures++; $display("FAIL rmid_cpu_rdata: got %h want %h", CpuRData, cpu_rd_exp); end
        cpu_chk = 0;
      end
      if (dbg_chk) begin
        checks++;
        if (DbgRData !== dbg_rd_exp) begin failures++; $display("FAIL rmid_dbg_rdata: got %h want %h", DbgRData, dbg_rd_exp); end
        dbg_chk = 0;
      end
      if (c == 1) begin
        checks++;
        if (DbgGnt !== 1'b1 || CpuGnt !== 1'b0) begin failures++; $display("FAIL rmid_tie: dbg=%b cpu=%b want 1 0", DbgGnt, CpuGnt); end
      end
      checks++;
      if (CpuReady !== (c == 7) || DbgReady !== (c == 3)) begin
        failures++; $display("FAIL rmid_ready c=%0d: cpu=%b dbg=%b", c, CpuReady, DbgReady);
      end
      if (CpuReady) begin ce = cpu_q.pop_front(); cpu_rd_exp = ce.data; cpu_chk = 1; CpuReq = 0; end
      if (DbgReady) begin de = dbg_q.pop_front(); dbg_rd_exp = de.data; dbg_chk = 1; DbgReq = 0; end
    end
  endtask

  task automatic test_lat1();
    exp_t e1;
    exp_t q1[$];
    logic [DW-1:0] rd_exp1;
    bit chk1 = 0;
    apply_reset();
    CpuReq1 = 1'b1; CpuWe1 = 1'b0; CpuAddr1 = 32'h10;
    e1.we = 1'b0; e1.data = 32'h0BAD_F00D;
    q1.push_back(e1);
    rd_exp1 = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      if (chk1) begin
        checks++;
        if (CpuRData1 !== rd_exp1) begin failures++; $display("FAIL lat1_rdata: got %h want %h", CpuRData1, rd_exp1); end
        chk1 = 0;
      end
      checks++;
      if (CpuReady1 !== (c == 2)) begin failures++; $display("FAIL lat1_ready c=%0d: got %b want %b", c, CpuReady1, (c == 2)); end
      checks++;
      if (u_dut1.cnt_q !== '0) begin failures++; $display("FAIL lat1_cnt c=%0d: got %0d want 0", c, u_dut1.cnt_q); end
      checks++;
      if (Stat1 !== ((c == 1) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL lat1_stat c=%0d: got %b", c, Stat1); end
      if (CpuReady1) begin e1 = q1.pop_front(); rd_exp1 = e1.data; chk1 = 1; CpuReq1 = 0; end
    end
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternation();
    test_dbg_write_halt();
    test_drop_mid();
    test_reset_mid();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
